program_loader: RTL and testbench

- Sequences the CPU instruction-memory download. Selects a stored program, streams it into the CPU write port one instruction per clock, holds the CPU in reset for the whole download, then releases it.
- Sits between the board-level switch/button logic and CPU; runs on the CPU clock domain (clk).
- Program images live in a small ROM sub-module.

---
 rtl/program_loader_pkg.sv | 25 ++
 rtl/program_loader_if.sv | 23 ++
 rtl/program_rom.sv | 68 ++++++
 rtl/program_loader.sv | 121 ++++++++++++
 tb/tb_program_loader.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
// Shared constants, FSM state type and program-id validity helper for the instruction-memory loader.
package program_loader_pkg;

    localparam int NUM_PROGRAMS = 3;
    localparam int BASE_INDEX   = 10;
    localparam int MAX_LEN      = 16;
    localparam int OFFSET_W     = $clog2(MAX_LEN);
    localparam int INSTR_W      = 16;

    localparam int PROG1_LEN = 13;
    localparam int PROG2_LEN = 7;
    localparam int PROG3_LEN = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RELEASE
    } state_t;

    // Ids 1..NUM_PROGRAMS name a stored image; 0 means "nothing loaded".
    function automatic logic is_valid_id(input logic [7:0] id);
        return (id != 8'd0) && (id <= 8'(NUM_PROGRAMS));
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// CPU-facing side of the loader: instruction-memory write port plus the CPU reset held during a download.
interface program_loader_if;

    logic                                   cpu_reset;
    logic                                   write_enable;
    logic [7:0]                             write_instruction_index;
    logic [program_loader_pkg::INSTR_W-1:0] write_instruction;

    modport master (
        output cpu_reset,
        output write_enable,
        output write_instruction_index,
        output write_instruction
    );

    modport slave (
        input cpu_reset,
        input write_enable,
        input write_instruction_index,
        input write_instruction
    );

endinterface

// File: rtl/program_rom.sv
// Combinational store of the program images: (id, offset) -> instruction word and last-word flag.
module program_rom
    import program_loader_pkg::*;
(
    input  logic [7:0]          i_id,
    input  logic [OFFSET_W-1:0] i_offset,
    output logic [INSTR_W-1:0]  o_instruction,
    output logic                o_last
);

    always_comb begin
        o_instruction = '0;
        o_last        = 1'b1;
        case (i_id)
            8'd1: begin
                o_last = (i_offset >= OFFSET_W'(PROG1_LEN - 1));
                case (i_offset)
                    4'd0:    o_instruction = 16'h2021;
                    4'd1:    o_instruction = 16'h0022;
                    4'd2:    o_instruction = 16'h0023;
                    4'd3:    o_instruction = 16'h202b;
                    4'd4:    o_instruction = 16'hfad0;
                    4'd5:    o_instruction = 16'h5200;
                    4'd6:    o_instruction = 16'h102b;
                    4'd7:    o_instruction = 16'h00da;
                    4'd8:    o_instruction = 16'h0132;
                    4'd9:    o_instruction = 16'h0133;
                    4'd10:   o_instruction = 16'h0a60;
                    4'd11:   o_instruction = 16'hf6e7;
                    4'd12:   o_instruction = 16'hfee7;
                    default: o_instruction = '0;
                endcase
            end
            8'd2: begin
                o_last = (i_offset >= OFFSET_W'(PROG2_LEN - 1));
                case (i_offset)
                    4'd0:    o_instruction = 16'h2021;
                    4'd1:    o_instruction = 16'h0020;
                    4'd2:    o_instruction = 16'h401c;
                    4'd3:    o_instruction = 16'h0860;
                    4'd4:    o_instruction = 16'hff28;
                    4'd5:    o_instruction = 16'hfbd1;
                    4'd6:    o_instruction = 16'he7fe;
                    default: o_instruction = '0;
                endcase
            end
            8'd3: begin
                o_last = (i_offset >= OFFSET_W'(PROG3_LEN - 1));
                case (i_offset)
                    4'd0:    o_instruction = 16'h0020;
                    4'd1:    o_instruction = 16'h0020;
                    4'd2:    o_instruction = 16'hd920;
                    4'd3:    o_instruction = 16'h2021;
                    4'd4:    o_instruction = 16'h0860;
                    4'd5:    o_instruction = 16'he7fe;
                    4'd6:    o_instruction = 16'h0240;
                    4'd7:    o_instruction = 16'h0240;
                    default: o_instruction = '0;
                endcase
            end
            default: begin
                o_instruction = '0;
                o_last        = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/program_loader.sv
// Downloads the selected program image into CPU instruction memory, one word per clock, holding the CPU in reset meanwhile.
module program_loader
    import program_loader_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       program_select,
    input  logic             load_request,
    program_loader_if.master cpu_bus,
    output logic             busy,
    output logic             done,
    output logic [7:0]       loaded_program,
    output logic             bad_select
);

    state_t              r_state,        w_state;
    logic [7:0]          r_id,           w_id;
    logic [OFFSET_W-1:0] r_offset,       w_offset;
    logic                r_cpu_reset,    w_cpu_reset;
    logic                r_write_enable, w_write_enable;
    logic [7:0]          r_index,        w_index;
    logic [INSTR_W-1:0]  r_instr,        w_instr;
    logic [7:0]          r_loaded,       w_loaded;
    logic                r_was_release;
    logic                r_done;
    logic                w_trigger;
    logic                w_rom_last;
    logic [INSTR_W-1:0]  w_rom_instr;

    program_rom u_rom (
        .i_id          (r_id),
        .i_offset      (r_offset),
        .o_instruction (w_rom_instr),
        .o_last        (w_rom_last)
    );

    assign bad_select = !is_valid_id(program_select);
    assign w_trigger  = !bad_select && ((program_select != r_loaded) || load_request);

    always_comb begin
        // NOTE: every next-value is defaulted before the case so no path leaves one unassigned, which would infer a latch.
        w_state        = r_state;
        w_id           = r_id;
        w_offset       = r_offset;
        w_cpu_reset    = r_cpu_reset;
        w_write_enable = 1'b0;
        w_index        = r_index;
        w_instr        = '0;
        w_loaded       = r_loaded;
        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_state     = LOAD;
                    w_id        = program_select;
                    w_offset    = '0;
                    w_cpu_reset = 1'b1;
                end else begin
                    w_cpu_reset = 1'b0;
                end
            end
            LOAD: begin
                w_write_enable = 1'b1;
                w_index        = 8'(BASE_INDEX) + 8'(r_offset);
                w_instr        = w_rom_instr;
                w_cpu_reset    = 1'b1;
                // The offset cap backs up the ROM's last flag so a bad image can never overrun the counter.
                if (w_rom_last || (r_offset == OFFSET_W'(MAX_LEN - 1))) begin
                    w_state = RELEASE;
                end else begin
                    w_offset = r_offset + 1'b1;
                end
            end
            RELEASE: begin
                w_cpu_reset = 1'b1;
                w_loaded    = r_id;
                w_state     = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            r_state        <= IDLE;
            r_id           <= '0;
            r_offset       <= '0;
            r_cpu_reset    <= 1'b1;
            r_write_enable <= 1'b0;
            r_index        <= '0;
            r_instr        <= '0;
            r_loaded       <= '0;
            r_was_release  <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_id           <= w_id;
            r_offset       <= w_offset;
            r_cpu_reset    <= w_cpu_reset;
            r_write_enable <= w_write_enable;
            r_index        <= w_index;
            r_instr        <= w_instr;
            r_loaded       <= w_loaded;
            // done lines up with the first IDLE cycle, the same edge cpu_reset is allowed to fall.
            r_was_release  <= (r_state == RELEASE);
            r_done         <= r_was_release;
        end
    end

    assign cpu_bus.cpu_reset               = r_cpu_reset;
    assign cpu_bus.write_enable            = r_write_enable;
    assign cpu_bus.write_instruction_index = r_index;
    assign cpu_bus.write_instruction       = r_instr;

    assign busy           = (r_state != IDLE);
    assign done           = r_done;
    assign loaded_program = r_loaded;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a cycle-level reference model predicts writes and status; a monitor compares.
module tb_program_loader;
    import program_loader_pkg::*;

    logic       clk            = 1'b0;
    logic       reset          = 1'b0;
    logic [7:0] program_select = 8'd0;
    logic       load_request   = 1'b0;
    logic       busy;
    logic       done;
    logic       bad_select;
    logic [7:0] loaded_program;

    program_loader_if cpu_bus ();

    program_loader dut (
        .clk            (clk),
        .reset          (reset),
        .program_select (program_select),
        .load_request   (load_request),
        .cpu_bus        (cpu_bus),
        .busy           (busy),
        .done           (done),
        .loaded_program (loaded_program),
        .bad_select     (bad_select)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    localparam logic [15:0] IMG1 [13] = '{16'h2021, 16'h0022, 16'h0023, 16'h202b, 16'hfad0, 16'h5200,
                                         16'h102b, 16'h00da, 16'h0132, 16'h0133, 16'h0a60, 16'hf6e7, 16'hfee7};
    localparam logic [15:0] IMG2 [7]  = '{16'h2021, 16'h0020, 16'h401c, 16'h0860, 16'hff28, 16'hfbd1, 16'he7fe};
    localparam logic [15:0] IMG3 [8]  = '{16'h0020, 16'h0020, 16'hd920, 16'h2021, 16'h0860, 16'he7fe, 16'h0240, 16'h0240};

    typedef struct {
        int          at;
        logic [7:0]  idx;
        logic [15:0] word;
    } wr_t;

    wr_t        exp_wr[$];
    int         exp_done[$];
    logic       exp_cpu_reset [int];
    logic       exp_busy [int];
    logic [7:0] exp_loaded [int];

    int model_loaded = 0;
    int pending_at   = -1;
    int pending_id   = 0;
    int next_eval    = 0;

    function automatic int img_len(input int id);
        case (id)
            1:       return 13;
            2:       return 7;
            3:       return 8;
            default: return 0;
        endcase
    endfunction

    function automatic logic [15:0] img_word(input int id, input int k);
        case (id)
            1:       return IMG1[k];
            2:       return IMG2[k];
            3:       return IMG3[k];
            default: return 16'h0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model, evaluated once per rising edge from the inputs that edge samples.
    task automatic model_step(input int e);
        int sel;
        int n;
        sel = int'(program_select);
        if (!reset) begin
            exp_wr.delete();
            exp_done.delete();
            model_loaded     = 0;
            pending_at       = -1;
            exp_cpu_reset[e] = 1'b1;
            exp_busy[e]      = 1'b0;
            next_eval        = e + 1;
        end else begin
            if (e >= next_eval) begin
                if (sel >= 1 && sel <= NUM_PROGRAMS && (sel != model_loaded || load_request)) begin
                    n = img_len(sel);
                    for (int k = 0; k < n; k++)
                        exp_wr.push_back('{at: e + 1 + k, idx: 8'(BASE_INDEX + k), word: img_word(sel, k)});
                    for (int c = e; c <= e + n; c++) begin
                        exp_cpu_reset[c] = 1'b1;
                        exp_busy[c]      = 1'b1;
                    end
                    exp_cpu_reset[e + n + 1] = 1'b1;
                    exp_busy[e + n + 1]      = 1'b0;
                    exp_done.push_back(e + n + 2);
                    pending_at = e + n + 1;
                    pending_id = sel;
                    next_eval  = e + n + 2;
                end else begin
                    exp_cpu_reset[e] = 1'b0;
                    exp_busy[e]      = 1'b0;
                    next_eval        = e + 1;
                end
            end
            if (e == pending_at) model_loaded = pending_id;
        end
        exp_loaded[e] = 8'(model_loaded);
    endtask

    task automatic monitor_step(input int e);
        logic exp_we;
        logic exp_d;
        wr_t  w;
        check($sformatf("cpu_reset@%0d", e), 32'(cpu_bus.cpu_reset),
              exp_cpu_reset.exists(e) ? 32'(exp_cpu_reset[e]) : 32'hx);
        check($sformatf("busy@%0d", e), 32'(busy), exp_busy.exists(e) ? 32'(exp_busy[e]) : 32'hx);
        check($sformatf("loaded_program@%0d", e), 32'(loaded_program), 32'(exp_loaded[e]));
        check($sformatf("bad_select@%0d", e), 32'(bad_select),
              32'((program_select == 8'd0) || (program_select > 8'(NUM_PROGRAMS))));
        exp_we = (exp_wr.size() > 0) && (exp_wr[0].at == e);
        check($sformatf("write_enable@%0d", e), 32'(cpu_bus.write_enable), 32'(exp_we));
        if (exp_we) begin
            w = exp_wr.pop_front();
            if (cpu_bus.write_enable === 1'b1) begin
                check($sformatf("index@%0d", e), 32'(cpu_bus.write_instruction_index), 32'(w.idx));
                check($sformatf("instruction@%0d", e), 32'(cpu_bus.write_instruction), 32'(w.word));
            end
        end else if (cpu_bus.write_enable !== 1'b1) begin
            check($sformatf("instruction_idle@%0d", e), 32'(cpu_bus.write_instruction), 32'h0);
        end
        exp_d = (exp_done.size() > 0) && (exp_done[0] == e);
        check($sformatf("done@%0d", e), 32'(done), 32'(exp_d));
        if (exp_d) void'(exp_done.pop_front());
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step(cyc);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) monitor_step(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_write(input logic [7:0] idx);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (cpu_bus.write_enable === 1'b1 && cpu_bus.write_instruction_index == idx) found = 1'b1;
        end
        check($sformatf("wait_write_%0d", idx), 32'(found), 32'h1);
        step(1);
    endtask

    task automatic wait_done();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (done === 1'b1) found = 1'b1;
        end
        check("wait_done", 32'(found), 32'h1);
        step(1);
    endtask

    initial begin
        reset          = 1'b0;
        program_select = 8'd0;
        load_request   = 1'b0;
        step(3);
        reset = 1'b1;
        step(5);

        program_select = 8'd1;
        wait_done();
        step(3);

        program_select = 8'd2;
        wait_done();
        step(3);

        load_request = 1'b1;
        step(1);
        load_request = 1'b0;
        wait_done();
        step(3);

        program_select = 8'd5;
        load_request   = 1'b1;
        step(1);
        load_request = 1'b0;
        step(10);

        program_select = 8'd1;
        wait_write(8'd12);
        program_select = 8'd3;
        wait_done();
        wait_done();
        step(3);

        program_select = 8'd2;
        wait_write(8'd13);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        wait_done();
        step(3);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 11) == 0) begin
                reset = 1'b0;
                step($urandom_range(1, 2));
                reset = 1'b1;
            end
            program_select = ($urandom_range(0, 9) == 0) ? 8'hff : 8'($urandom_range(0, 4));
            load_request   = ($urandom_range(0, 2) == 0);
            step(1);
            load_request = 1'b0;
            step($urandom_range(0, 20));
        end

        program_select = 8'd1;
        load_request   = 1'b0;
        reset          = 1'b1;
        step(60);
        check("pending_writes", 32'(exp_wr.size()), 32'h0);
        check("pending_done", 32'(exp_done.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
